// File: rtl/audio_mix_n.sv
// Mixes NCH signed mono sources into a saturated stereo pair through one shared MAC, with a ramped mute.
// Latency: sample_ce in cycle 0 -> out_valid in cycle NCH+2; busy covers cycles 1..NCH+2.
// Backpressure: none; sample_ce while busy is dropped and flagged with a same-cycle overrun pulse.
module audio_mix_n #(
  parameter int NCH       = 4,
  parameter int IW        = 16,
  parameter int OW        = 16,
  parameter int GW        = 8,
  parameter int RAMP_STEP = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_ce,
  input  logic [NCH*IW-1:0] in_data,
  input  logic [NCH-1:0]    in_valid,
  input  logic [NCH*GW-1:0] gain,
  input  logic [NCH-1:0]    pan_l,
  input  logic [NCH-1:0]    pan_r,
  input  logic              mute,
  output logic [OW-1:0]     out_l,
  output logic [OW-1:0]     out_r,
  output logic              out_valid,
  output logic              clip_l,
  output logic              clip_r,
  output logic              busy,
  output logic              overrun
);

  localparam int KW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW    = IW + GW + 1;
  localparam int AW    = PW + $clog2(NCH);
  localparam int SW    = AW + GW + 1 + (OW - IW);
  localparam int UNITY = 2 ** (GW - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MAC   = 2'd1;
  localparam logic [1:0] S_SCALE = 2'd2;
  localparam logic [1:0] S_SAT   = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [NCH*IW-1:0]    hold_q, hold_d;
  logic [NCH*IW-1:0]    hold_w_q, hold_w_d;
  logic [NCH*GW-1:0]    gain_w_q, gain_w_d;
  logic [NCH-1:0]       pan_l_w_q, pan_l_w_d;
  logic [NCH-1:0]       pan_r_w_q, pan_r_w_d;
  logic                 mute_w_q, mute_w_d;
  logic signed [AW-1:0] acc_l_q, acc_l_d;
  logic signed [AW-1:0] acc_r_q, acc_r_d;
  logic [GW-1:0]        ramp_q, ramp_d;
  logic [OW-1:0]        out_l_q, out_l_d;
  logic [OW-1:0]        out_r_q, out_r_d;
  logic                 out_valid_q, out_valid_d;
  logic                 clip_l_q, clip_l_d;
  logic                 clip_r_q, clip_r_d;

  logic signed [PW-1:0] p;
  logic signed [AW-1:0] p_ext;
  logic [OW:0]          sat_l, sat_r;
  int                   ramp_nxt;

  // Rescale an accumulator by the gain and mute-ramp fractions, then clamp to OW bits; MSB is the clip flag.
  function automatic logic [OW:0] scale_sat(input logic signed [AW-1:0] acc, input logic [GW-1:0] rmp);
    logic signed [AW-1:0] a;
    logic signed [SW-1:0] prod;
    logic signed [SW-1:0] v;
    logic signed [SW-1:0] vmax;
    logic signed [SW-1:0] vmin;
    logic                 clip;
    logic [OW-1:0]        res;
    a    = acc >>> (GW - 1);
    prod = SW'(a) * SW'($signed({1'b0, rmp}));
    v    = (prod >>> (GW - 1)) <<< (OW - IW);
    vmax = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    vmin = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};
    clip = 1'b1;
    if (v > vmax) begin
      res = vmax[OW-1:0];
    end else if (v < vmin) begin
      res = vmin[OW-1:0];
    end else begin
      clip = 1'b0;
      res  = v[OW-1:0];
    end
    return {clip, res};
  endfunction

  // Next-state logic: hold loading, snapshot, MAC walk, scale/saturate and ramp update.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    hold_d      = hold_q;
    hold_w_d    = hold_w_q;
    gain_w_d    = gain_w_q;
    pan_l_w_d   = pan_l_w_q;
    pan_r_w_d   = pan_r_w_q;
    mute_w_d    = mute_w_q;
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    ramp_d      = ramp_q;
    out_l_d     = out_l_q;
    out_r_d     = out_r_q;
    out_valid_d = 1'b0;
    clip_l_d    = 1'b0;
    clip_r_d    = 1'b0;

    p     = $signed(hold_w_q[k_q*IW +: IW]) * $signed({1'b0, gain_w_q[k_q*GW +: GW]});
    p_ext = AW'(p);
    sat_l = scale_sat(acc_l_q, ramp_q);
    sat_r = scale_sat(acc_r_q, ramp_q);

    if (mute_w_q) begin
      ramp_nxt = int'(ramp_q) - RAMP_STEP;
      if (ramp_nxt < 0) ramp_nxt = 0;
    end else begin
      ramp_nxt = int'(ramp_q) + RAMP_STEP;
      if (ramp_nxt > UNITY) ramp_nxt = UNITY;
    end

    for (int i = 0; i < NCH; i++) begin
      if (in_valid[i]) hold_d[i*IW +: IW] = in_data[i*IW +: IW];
    end

    case (state_q)
      S_IDLE: begin
        if (sample_ce) begin
          hold_w_d  = hold_q;
          gain_w_d  = gain;
          pan_l_w_d = pan_l;
          pan_r_w_d = pan_r;
          mute_w_d  = mute;
          acc_l_d   = '0;
          acc_r_d   = '0;
          k_d       = '0;
          state_d   = S_MAC;
        end
      end
      S_MAC: begin
        acc_l_d = acc_l_q + (pan_l_w_q[k_q] ? p_ext : '0);
        acc_r_d = acc_r_q + (pan_r_w_q[k_q] ? p_ext : '0);
        if (k_q == KW'(NCH - 1)) begin
          state_d = S_SCALE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_SCALE: begin
        // Outputs are registered here so they are already visible during the SAT cycle with out_valid.
        out_l_d     = sat_l[OW-1:0];
        out_r_d     = sat_r[OW-1:0];
        clip_l_d    = sat_l[OW];
        clip_r_d    = sat_r[OW];
        out_valid_d = 1'b1;
        ramp_d      = GW'(ramp_nxt);
        state_d     = S_SAT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any sample in flight and restarts the ramp from silence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      hold_q      <= '0;
      hold_w_q    <= '0;
      gain_w_q    <= '0;
      pan_l_w_q   <= '0;
      pan_r_w_q   <= '0;
      mute_w_q    <= 1'b0;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      ramp_q      <= '0;
      out_l_q     <= '0;
      out_r_q     <= '0;
      out_valid_q <= 1'b0;
      clip_l_q    <= 1'b0;
      clip_r_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      hold_q      <= hold_d;
      hold_w_q    <= hold_w_d;
      gain_w_q    <= gain_w_d;
      pan_l_w_q   <= pan_l_w_d;
      pan_r_w_q   <= pan_r_w_d;
      mute_w_q    <= mute_w_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      ramp_q      <= ramp_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
      out_valid_q <= out_valid_d;
      clip_l_q    <= clip_l_d;
      clip_r_q    <= clip_r_d;
    end
  end

  assign out_l     = out_l_q;
  assign out_r     = out_r_q;
  assign out_valid = out_valid_q;
  assign clip_l    = clip_l_q;
  assign clip_r    = clip_r_q;
  assign busy      = (state_q != S_IDLE);
  assign overrun   = sample_ce & busy;

endmodule

// File: tb/tb_audio_mix_n.sv
module tb_audio_mix_n;
  localparam int NCH = 4;
  localparam int IW  = 16;
  localparam int OW  = 16;
  localparam int GW  = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              sample_ce;
  logic [NCH*IW-1:0] in_data;
  logic [NCH-1:0]    in_valid;
  logic [NCH*GW-1:0] gain;
  logic [NCH-1:0]    pan_l;
  logic [NCH-1:0]    pan_r;
  logic              mute;
  logic [OW-1:0]     out_l;
  logic [OW-1:0]     out_r;
  logic              out_valid;
  logic              clip_l;
  logic              clip_r;
  logic              busy;
  logic              overrun;

  int checks   = 0;
  int failures = 0;
  int ov_count = 0;
  int n_push   = 0;
  logic [33:0] exp_q[$];
  logic [33:0] mon_e;

  audio_mix_n #(.NCH(NCH), .IW(IW), .OW(OW), .GW(GW), .RAMP_STEP(16)) dut (
    .clk(clk), .reset_n(reset_n), .sample_ce(sample_ce), .in_data(in_data),
    .in_valid(in_valid), .gain(gain), .pan_l(pan_l), .pan_r(pan_r), .mute(mute),
    .out_l(out_l), .out_r(out_r), .out_valid(out_valid), .clip_l(clip_l),
    .clip_r(clip_r), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every out_valid pops one expected result.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && out_valid === 1'b1) begin
      ov_count++;
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_l", 32'(out_l), 32'(mon_e[33:18]));
        chk("out_r", 32'(out_r), 32'(mon_e[17:2]));
        chk("clip_l", 32'(clip_l), 32'(mon_e[1]));
        chk("clip_r", 32'(clip_r), 32'(mon_e[0]));
      end
    end
  end

  task automatic push_exp(input logic [15:0] el, input logic [15:0] er, input logic ecl, input logic ecr);
    exp_q.push_back({el, er, ecl, ecr});
    n_push++;
  endtask

  task automatic set_src(input int i, input logic [15:0] d, input logic [7:0] g, input logic pl, input logic pr);
    @(negedge clk);
    in_data[i*IW +: IW] = d;
    in_valid[i] = 1'b1;
    gain[i*GW +: GW] = g;
    pan_l[i] = pl;
    pan_r[i] = pr;
    @(negedge clk);
    in_valid = '0;
  endtask

  task automatic run_sample(input string tag, input logic [15:0] el, input logic [15:0] er,
                            input logic ecl, input logic ecr);
    int cyc;
    push_exp(el, er, ecl, ecr);
    @(negedge clk);
    sample_ce = 1'b1;
    @(negedge clk);
    sample_ce = 1'b0;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd6);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int cyc;
    reset_n = 1'b0; sample_ce = 1'b0; in_data = '0; in_valid = '0;
    gain = '0; pan_l = '0; pan_r = '0; mute = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_out_l", 32'(out_l), 32'd0);
    chk("rst_out_r", 32'(out_r), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_clip", 32'({clip_l, clip_r}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset_n = 1'b1;

    // Fade-in from reset: ramp starts at 0 and reaches unity after 8 samples.
    set_src(0, 16'h1000, 8'h80, 1'b1, 1'b1);
    for (int i = 1; i < NCH; i++) set_src(i, 16'h0000, 8'h80, 1'b0, 1'b0);
    for (int j = 0; j < 9; j++) run_sample("fadein", 16'(j * 512), 16'(j * 512), 1'b0, 1'b0);
    run_sample("unity", 16'h1000, 16'h1000, 1'b0, 1'b0);

    // Gain and pan.
    set_src(0, 16'h0000, 8'h80, 1'b0, 1'b0);
    set_src(1, 16'h4000, 8'h40, 1'b1, 1'b0);
    run_sample("gain_half", 16'h2000, 16'h0000, 1'b0, 1'b0);
    set_src(1, 16'h4000, 8'hFF, 1'b1, 1'b0);
    run_sample("gain_ff", 16'h7F80, 16'h0000, 1'b0, 1'b0);

    // Saturation both directions.
    for (int i = 0; i < NCH; i++) set_src(i, 16'h7000, 8'h80, 1'b1, 1'b1);
    run_sample("sat_pos", 16'h7FFF, 16'h7FFF, 1'b1, 1'b1);
    for (int i = 0; i < NCH; i++) set_src(i, 16'h9000, 8'h80, 1'b1, 1'b1);
    run_sample("sat_neg", 16'h8000, 16'h8000, 1'b1, 1'b1);

    // Overrun mid-MAC, with a hold update during MAC that must not affect this sample.
    set_src(0, 16'h1000, 8'h80, 1'b1, 1'b1);
    for (int i = 1; i < NCH; i++) set_src(i, 16'h0000, 8'h00, 1'b0, 1'b0);
    push_exp(16'h1000, 16'h1000, 1'b0, 1'b0);
    @(negedge clk); sample_ce = 1'b1;
    @(negedge clk); sample_ce = 1'b0;
    @(negedge clk); in_data[IW-1:0] = 16'h7FFF; in_valid[0] = 1'b1;
    @(negedge clk); in_valid = '0; sample_ce = 1'b1;
    #1;
    chk("overrun_mac", 32'(overrun), 32'd1);
    chk("busy_mac", 32'(busy), 32'd1);
    @(negedge clk); sample_ce = 1'b0;
    #1;
    chk("overrun_pulse_end", 32'(overrun), 32'd0);
    cyc = 4;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("overrun_latency", 32'(cyc), 32'd6);
    for (int j = 0; j < 10; j++) @(negedge clk);

    // sample_ce on the SAT cycle counts as overrun and is dropped.
    run_sample("new_hold", 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
    sample_ce = 1'b1;
    #1;
    chk("overrun_sat", 32'(overrun), 32'd1);
    @(negedge clk); sample_ce = 1'b0;
    #1;
    chk("idle_after_sat", 32'(busy), 32'd0);
    for (int j = 0; j < 10; j++) @(negedge clk);
    chk("single_out_valid", 32'(ov_count), 32'(n_push));

    // Mute ramp down then back up.
    set_src(0, 16'h1000, 8'h80, 1'b1, 1'b1);
    mute = 1'b1;
    for (int j = 0; j < 9; j++) run_sample("mute", 16'(4096 - j * 512), 16'(4096 - j * 512), 1'b0, 1'b0);
    mute = 1'b0;
    for (int j = 0; j < 3; j++) run_sample("unmute", 16'(j * 512), 16'(j * 512), 1'b0, 1'b0);

    // Reset in cycle 2 of a sample: aborted, no out_valid, ramp restarts.
    @(negedge clk); sample_ce = 1'b1;
    @(negedge clk); sample_ce = 1'b0;
    @(negedge clk); reset_n = 1'b0;
    #1;
    chk("midrst_out_l", 32'(out_l), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk); @(negedge clk); reset_n = 1'b1;
    for (int j = 0; j < 10; j++) @(negedge clk);
    chk("midrst_no_valid", 32'(ov_count), 32'(n_push));
    set_src(0, 16'h1000, 8'h80, 1'b1, 1'b1);
    run_sample("post_rst0", 16'h0000, 16'h0000, 1'b0, 1'b0);
    run_sample("post_rst1", 16'h0200, 16'h0200, 1'b0, 1'b0);

    // Negative source during fade-in: ramp 32 -> -0x1000 * 32/128 = -0x400.
    set_src(0, 16'hF000, 8'h80, 1'b1, 1'b0);
    run_sample("neg_ramp", 16'hFC00, 16'h0000, 1'b0, 1'b0);

    for (int j = 0; j < 4; j++) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("out_valid_count", 32'(ov_count), 32'(n_push));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
